// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid-tagged pipeline register with stall/flush.
// Optional stall-cycle counter is built only when PIPE_STALL_CNT_EN is defined.
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be in 1..8");
    end

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;

    // Stage chain: clear/flush to bubbles, hold on stall, otherwise shift one stage.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= BUBBLE;
            vld <= '0;
        end else if (!stall) begin
            data[0] <= d_valid ? d : BUBBLE;
            vld[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
                vld[i] <= vld[i-1];
            end
        end
    end

    assign q = data[DEPTH-1];
    assign q_valid = vld[DEPTH-1];
    assign busy = |vld;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of cycles spent stalled with work in flight.
    always_ff @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (!flush && stall && busy && cnt != '1) cnt <= cnt + CNT_W'(1);
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: checks three pipe_reg_chain instances (DEPTH 1/2/3) against a queue model.
module tb_pipe_reg_chain;
`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 0, clr = 0, d_valid = 0, stall = 0, flush = 0;
    logic [31:0] d = 0;
    logic [31:0] q1, q2, q3;
    logic qv1, qv2, qv3, b1, b2, b3;
    logic [15:0] c1, c3;
    logic [3:0] c2;

    pipe_reg_chain #(.DEPTH(1)) u1 (.clk(clk), .clr(clr), .d(d), .d_valid(d_valid), .stall(stall),
        .flush(flush), .q(q1), .q_valid(qv1), .busy(b1), .stall_cnt(c1));
    pipe_reg_chain #(.DEPTH(2), .CNT_W(4)) u2 (.clk(clk), .clr(clr), .d(d), .d_valid(d_valid), .stall(stall),
        .flush(flush), .q(q2), .q_valid(qv2), .busy(b2), .stall_cnt(c2));
    pipe_reg_chain #(.DEPTH(3)) u3 (.clk(clk), .clr(clr), .d(d), .d_valid(d_valid), .stall(stall),
        .flush(flush), .q(q3), .q_valid(qv3), .busy(b3), .stall_cnt(c3));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic v; } st_t;
    typedef struct { logic [31:0] d; logic dv; logic [31:0] eq; logic ev; } vec_t;

    st_t sb [3][$];
    int cm [3];
    int cmax [3] = '{65535, 15, 65535};
    int dep [3] = '{1, 2, 3};
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    function automatic void mreset(input int k);
        sb[k].delete();
        for (int i = 0; i < dep[k]; i++) sb[k].push_back('{32'h0, 1'b0});
    endfunction

    function automatic logic mbusy(input int k);
        logic b = 0;
        foreach (sb[k][i]) b |= sb[k][i].v;
        return b;
    endfunction

    task automatic step(input logic [31:0] dd, input logic dv, input logic st, input logic fl, input logic cl);
        d = dd; d_valid = dv; stall = st; flush = fl; clr = cl;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            logic b;
            b = mbusy(k);
            if (cl) begin
                mreset(k);
                cm[k] = 0;
            end else if (fl) mreset(k);
            else if (st) begin
                if (b && cm[k] < cmax[k]) cm[k]++;
            end else begin
                sb[k].push_back('{dv ? dd : 32'h0, dv});
                void'(sb[k].pop_front());
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] aq, ac;
            logic av, ab;
            st_t e;
            aq = k == 0 ? q1 : k == 1 ? q2 : q3;
            av = k == 0 ? qv1 : k == 1 ? qv2 : qv3;
            ab = k == 0 ? b1 : k == 1 ? b2 : b3;
            ac = k == 0 ? 32'(c1) : k == 1 ? 32'(c2) : 32'(c3);
            e = sb[k][0];
            chk($sformatf("m%0d_q", k + 1), aq, e.d);
            chk($sformatf("m%0d_qv", k + 1), 32'(av), 32'(e.v));
            chk($sformatf("m%0d_busy", k + 1), 32'(ab), 32'(mbusy(k)));
            chk($sformatf("m%0d_cnt", k + 1), ac, CNT_EN ? cm[k] : 0);
        end
    endtask

    initial begin
        vec_t tv [6];
        for (int k = 0; k < 3; k++) begin
            mreset(k);
            cm[k] = 0;
        end
        step(0, 0, 0, 0, 1);

        // T1: random traffic then a clear
        for (int i = 0; i < 40; i++)
            step($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 0);
        step($urandom, 1, 1, 1, 1);
        chk("t1_q3", q3, 0);
        chk("t1_qv2", 32'(qv2), 0);
        chk("t1_busy3", 32'(b3), 0);
        chk("t1_cnt1", 32'(c1), 0);

        // T2: DEPTH=3 latency
        tv[0] = '{32'h11, 1, 32'h0, 0};
        tv[1] = '{32'h22, 1, 32'h0, 0};
        tv[2] = '{32'h33, 1, 32'h11, 1};
        tv[3] = '{32'h0, 0, 32'h22, 1};
        tv[4] = '{32'h0, 0, 32'h33, 1};
        tv[5] = '{32'h0, 0, 32'h0, 0};
        for (int i = 0; i < 6; i++) begin
            step(tv[i].d, tv[i].dv, 0, 0, 0);
            chk($sformatf("t2_q_%0d", i), q3, tv[i].eq);
            chk($sformatf("t2_v_%0d", i), 32'(qv3), 32'(tv[i].ev));
        end

        // T3: DEPTH=2 stall holds, d ignored
        step(0, 0, 0, 0, 1);
        step(32'hA5A5A5A5, 1, 0, 0, 0);
        repeat (4) step(32'hFFFFFFFF, 1, 1, 0, 0);
        chk("t3_cnt", 32'(c2), CNT_EN ? 4 : 0);
        chk("t3_qv_held", 32'(qv2), 0);
        step(0, 0, 0, 0, 0);
        chk("t3_q", q2, 32'hA5A5A5A5);
        chk("t3_qv", 32'(qv2), 1);
        step(0, 0, 0, 0, 0);
        chk("t3_no_capture", q2, 0);

        // T4: flush beats stall, counter holds
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(2, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(3, 1, 1, 1, 0);
        chk("t4_busy", 32'(b2), 0);
        chk("t4_qv", 32'(qv2), 0);
        chk("t4_q", q2, 0);
        chk("t4_cnt", 32'(c2), CNT_EN ? 1 : 0);

        // T5: invalid data becomes bubble at DEPTH=1
        step(7, 1, 0, 0, 0);
        chk("t5_pre", q1, 7);
        step(32'hDEADBEEF, 0, 0, 0, 0);
        chk("t5_q", q1, 0);
        chk("t5_qv", 32'(qv1), 0);

        // T6: saturation at CNT_W=4
        step(0, 0, 0, 0, 1);
        step(5, 1, 0, 0, 0);
        repeat (20) step(9, 1, 1, 0, 0);
        chk("t6_cnt2", 32'(c2), CNT_EN ? 15 : 0);
        chk("t6_cnt1", 32'(c1), CNT_EN ? 20 : 0);
        step(0, 0, 0, 0, 1);
        chk("t6_clr", 32'(c2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
